// File: rtl/std_pkg.sv
// Shared constants for the std datapath blocks: skid buffer state encoding.
package std_pkg;

    localparam int STD_SKID_STATE_W = 2;

    localparam logic [STD_SKID_STATE_W-1:0] STD_SKID_EMPTY = 2'b00;
    localparam logic [STD_SKID_STATE_W-1:0] STD_SKID_BUSY  = 2'b01;
    localparam logic [STD_SKID_STATE_W-1:0] STD_SKID_FULL  = 2'b10;

endpackage

// File: rtl/std_skid_buffer.sv
// Two-entry elastic pipeline register. s_ready and m_valid are pure decodes of
// the state flop, so there is no combinational path from m_ready to s_ready.
module std_skid_buffer
    import std_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    logic [STD_SKID_STATE_W-1:0] state_q, state_d;
    logic [DATA_WIDTH-1:0]       out_q, out_d;
    logic [DATA_WIDTH-1:0]       skid_q, skid_d;
    logic                        acc, pop;

    // Unused encoding 2'b11 decodes like EMPTY: no valid output, ready to accept.
    assign m_valid = (state_q == STD_SKID_BUSY) || (state_q == STD_SKID_FULL);
    assign s_ready = (state_q != STD_SKID_FULL);
    assign m_data  = out_q;

    assign acc = s_valid && s_ready;
    assign pop = m_valid && m_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            STD_SKID_BUSY: begin
                if (acc && pop) begin
                    out_d = s_data;
                end else if (acc) begin
                    skid_d  = s_data;
                    state_d = STD_SKID_FULL;
                end else if (pop) begin
                    state_d = STD_SKID_EMPTY;
                end
            end
            STD_SKID_FULL: begin
                if (pop) begin
                    out_d   = skid_q;
                    state_d = STD_SKID_BUSY;
                end
            end
            default: begin
                // EMPTY and the illegal encoding both land in a legal state.
                state_d = STD_SKID_EMPTY;
                if (acc) begin
                    out_d   = s_data;
                    state_d = STD_SKID_BUSY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STD_SKID_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_std_skid_buffer.sv
// Self-checking bench for std_skid_buffer: directed vector table, stall and
// streaming sequences, then random traffic against a reference queue.
module tb_std_skid_buffer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;

    int total = 0;
    int bad   = 0;

    std_skid_buffer #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         sv;
        logic [W-1:0] sd;
        logic         mr;
        logic         emv;
        logic         esr;
        logic [W-1:0] emd;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic sv, input logic [W-1:0] sd, input logic mr);
        reset   = r;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
    endtask

    logic [W-1:0] q[$];
    logic [W-1:0] exp_w;
    logic         sr_a, acc, pop;

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        // Inputs held for one cycle; expected outputs observed just after the edge.
        vecs[0]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};
        vecs[4]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11};
        vecs[5]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h11};
        vecs[6]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22};
        vecs[7]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33};
        vecs[8]  = '{1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 8'h33};
        vecs[9]  = '{1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 8'hC1};
        vecs[10] = '{1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 8'hC1};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[14] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A};

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].sv, vecs[i].sd, vecs[i].mr);
            @(posedge clk);
            #1;
            $display("vec %0d: rst=%0b sv=%0b sd=%02h mr=%0b -> mv=%0b sr=%0b md=%02h",
                     i, vecs[i].rst, vecs[i].sv, vecs[i].sd, vecs[i].mr, m_valid, s_ready, m_data);
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].emv));
            chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].esr));
            chk($sformatf("vec%0d_m_data", i),  32'(m_data),  32'(vecs[i].emd));
        end

        // Stall: BUSY holding 5A, downstream blocked for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 8'hEE, 1'b0);
            @(posedge clk);
            #1;
            $display("stall %0d: mv=%0b md=%02h", i, m_valid, m_data);
            chk("stall_m_valid", 32'(m_valid), 32'd1);
            chk("stall_m_data",  32'(m_data),  32'h5A);
        end

        // Streaming at full throughput: 5A pops while 01 is accepted, then one per cycle.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, W'(i), 1'b1);
            @(posedge clk);
            #1;
            $display("stream %0d: mv=%0b sr=%0b md=%02h", i, m_valid, s_ready, m_data);
            chk("stream_m_valid", 32'(m_valid), 32'd1);
            chk("stream_s_ready", 32'(s_ready), 32'd1);
            chk("stream_m_data",  32'(m_data),  32'(i));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        chk("stream_drain_m_valid", 32'(m_valid), 32'd0);

        // Random traffic against a reference FIFO of depth two.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            chk("rnd_m_valid", 32'(m_valid), 32'(q.size() != 0));
            chk("rnd_s_ready", 32'(s_ready), 32'(q.size() < 2));
            if (q.size() != 0) begin
                exp_w = q[0];
                chk("rnd_m_data", 32'(m_data), 32'(exp_w));
            end
            sr_a = s_ready;
            drive(1'b0, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
            #1;
            chk("rnd_s_ready_comb", 32'(s_ready), 32'(sr_a));
            acc = s_valid && s_ready;
            pop = m_valid && m_ready;
            if (pop && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(s_data);
            @(posedge clk);
            #1;
        end
        $display("random traffic: %0d cycles, %0d words left in model", 10000, q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
